expr_eval: RTL and testbench
============================

# expr_eval

Downstream evaluator for the digit-expression character stream checked by the string recognizer. It consumes the same 8-bit ASCII stream, one character per valid cycle. It computes the integer value of expressions of the form digit((+|*)digit)*, with `*` binding tighter than `+`. A `=` character terminates each expression and triggers a one-cycle result report, then evaluation restarts for the next expression.

## Interface
- No parameters. Result width is fixed at 16 bits.
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous, active-low reset
- in  in  8  ASCII character
- in_valid  in  1  `in` carries a character this cycle; ignored when low
- ok  out  1  stream so far is a complete, well-formed expression (state GOT_D)
- res_valid  out  1  one-cycle pulse: `res` and `err` are valid
- res  out  16  expression value modulo 2^16; 0 when `err` is set
- err  out  1  expression was malformed (qualified by `res_valid`)

## Operation
- Character classes:
  - DIG: "0".."9", value d = in − 8'h30
  - ADD: "+"
  - MUL: "*"
  - EQ: "="
  - OTHER: everything else
- State: `st` ∈ {EXP_D, GOT_D, ERR}, plus a `mul_pend` flag, a 16-bit sum `S` and a 16-bit term `P`.
- Fresh state: st=EXP_D, S=0, P=0, mul_pend=0.
- EXP_D:
  - DIG → P = mul_pend ? P·d : d; go to GOT_D.
  - EQ → report err=1, res=0; return to fresh state.
  - Other classes → ERR.
- GOT_D:
  - ADD → S = S+P, mul_pend=0; go to EXP_D.
  - MUL → mul_pend=1; go to EXP_D.
  - EQ → report res=S+P, err=0; return to fresh state.
  - DIG or OTHER → ERR.
- ERR:
  - Every character except EQ → stay in ERR.
  - EQ → report err=1, res=0; return to fresh state.
- Arithmetic is unsigned, truncated to 16 bits after every add and multiply. Wrap-around is silent and is not an error.
- in_valid=0 → no state change. Cycles with no valid character between characters are legal.

## Timing
- Reset (clr_n low, asynchronous): st=EXP_D, S=P=0, mul_pend=0, ok=0, res_valid=0, res=0, err=0. Release is synchronous to clk.
- Reset asserted mid-expression discards the partial expression. No `res_valid` is issued for it.
- `ok`, `res`, `err` and `res_valid` are registered.
  - `ok` reflects the state after the last accepted character, one cycle after that character.
- EQ accepted at edge N → `res_valid`=1 during cycle N+1 only.
  - `res` and `err` hold their values until the next report or reset.
- A DIG arriving in the cycle right after EQ belongs to the new expression. Back-to-back expressions need no gap cycles.
- Throughput: one character per clock. No backpressure.

## Structure
- Shared package `expr_pkg`:
  - state enum {EXP_D, GOT_D, ERR}
  - ASCII constants CH_0, CH_9, CH_ADD, CH_MUL, CH_EQ
  - RES_W = 16
- Sub-module `char_class`: combinational decode of `in` into a class and a 4-bit digit value.
- FSM and datapath live in `expr_eval`.

## Test plan
- "1+2*3=" with in_valid held high → ok toggles 1,0,1,0,1; res_valid pulse with res=7, err=0.
- "9*9*9*9*9=" → res=59049. Then "9*9*9*9*9*9=" → res=7153 (531441 mod 65536), err=0.
- "1++2=" and "+3=" → err=1, res=0. The ERR state persists through the remaining characters and clears after `=`.
- "2*3+4=5+5=" back-to-back with no gaps → two pulses, res=10 then res=10. "=" alone → err=1.
- "4*5" with in_valid=0 gap cycles inserted, then "=" → res=20. Results are unaffected by the gaps.
- Pull clr_n low after "7+8" with no `=` → outputs clear immediately, no pulse. Then "3=" → res=3.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared types and constants for the digit-expression evaluator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package expr_pkg;

  localparam int RES_W = 16;

  typedef logic [RES_W-1:0] word_t;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_EQ  = 8'h3D;

  // Parser state: expecting a digit, just got a digit, or poisoned until '='.
  typedef enum logic [1:0] {
    EXP_D = 2'd0,
    GOT_D = 2'd1,
    ERR   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CL_DIG   = 3'd0,
    CL_ADD   = 3'd1,
    CL_MUL   = 3'd2,
    CL_EQ    = 3'd3,
    CL_OTHER = 3'd4
  } cls_t;

endpackage

// File: rtl/expr_eval_char_class.sv
// Decodes one ASCII character into a character class and its digit value.
// Latency: combinational.
// Backpressure: none.
// Ports: ch_i  - ASCII character
//        cls_o - class (digit, '+', '*', '=', other)
//        dig_o - numeric value for digits, 0 otherwise
module char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch_i,
  output cls_t       cls_o,
  output logic [3:0] dig_o
);

  logic [7:0] ofs;
  assign ofs = ch_i - CH_0;

  always_comb begin
    cls_o = CL_OTHER;
    dig_o = 4'd0;
    if (ch_i >= CH_0 && ch_i <= CH_9) begin
      cls_o = CL_DIG;
      dig_o = ofs[3:0];
    end else if (ch_i == CH_ADD) begin
      cls_o = CL_ADD;
    end else if (ch_i == CH_MUL) begin
      cls_o = CL_MUL;
    end else if (ch_i == CH_EQ) begin
      cls_o = CL_EQ;
    end
  end

endmodule

// File: rtl/expr_eval.sv
// Evaluates digit((+|*)digit)* expressions terminated by '=', with '*' binding tighter than '+'.
// Latency: result reported one cycle after the '=' is accepted; ok follows each character by one cycle.
// Backpressure: none; one character per clock whenever in_valid is high.
// Ports: clk, clr_n (async active-low) | in, in_valid - character stream
//        ok - well-formed so far | res_valid, res, err - one-cycle result report
module expr_eval
  import expr_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             ok,
  output logic             res_valid,
  output logic [RES_W-1:0] res,
  output logic             err
);

  cls_t       cls;
  logic [3:0] dig;

  char_class u_char_class (
    .ch_i  (in),
    .cls_o (cls),
    .dig_o (dig)
  );

  state_t st_q;
  word_t  sum_q;       // sum of completed additive terms
  word_t  term_q;      // running product of the current term
  logic   mul_pend_q;  // next digit multiplies into term_q instead of starting it
  logic   ok_q;
  logic   res_valid_q;
  word_t  res_q;
  logic   err_q;

  word_t dig_w;
  assign dig_w = word_t'(dig);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      st_q        <= EXP_D;
      sum_q       <= '0;
      term_q      <= '0;
      mul_pend_q  <= 1'b0;
      ok_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      if (in_valid) begin
        if (cls == CL_EQ) begin
          // '=' always reports and restarts; only a digit-terminated stream is valid.
          res_valid_q <= 1'b1;
          if (st_q == GOT_D) begin
            res_q <= sum_q + term_q;
            err_q <= 1'b0;
          end else begin
            res_q <= '0;
            err_q <= 1'b1;
          end
          st_q       <= EXP_D;
          sum_q      <= '0;
          term_q     <= '0;
          mul_pend_q <= 1'b0;
          ok_q       <= 1'b0;
        end else begin
          case (st_q)
            EXP_D: begin
              if (cls == CL_DIG) begin
                term_q <= mul_pend_q ? term_q * dig_w : dig_w;
                st_q   <= GOT_D;
                ok_q   <= 1'b1;
              end else begin
                st_q <= ERR;
                ok_q <= 1'b0;
              end
            end
            GOT_D: begin
              ok_q <= 1'b0;
              if (cls == CL_ADD) begin
                sum_q      <= sum_q + term_q;
                mul_pend_q <= 1'b0;
                st_q       <= EXP_D;
              end else if (cls == CL_MUL) begin
                mul_pend_q <= 1'b1;
                st_q       <= EXP_D;
              end else begin
                st_q <= ERR;
              end
            end
            default: begin
              st_q <= ERR;
              ok_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign ok        = ok_q;
  assign res_valid = res_valid_q;
  assign res       = res_q;
  assign err       = err_q;

endmodule

// File: tb/tb_expr_eval.sv
// Directed self-checking bench for expr_eval.
// Latency: n/a.
// Backpressure: n/a.
module tb_expr_eval;

  logic        clk;
  logic        clr_n;
  logic [7:0]  in_ch;
  logic        in_valid;
  logic        ok;
  logic        res_valid;
  logic [15:0] res;
  logic        err;

  int n_checks;
  int n_errors;

  logic [15:0] res_log[$];
  logic        err_log[$];

  expr_eval dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .in        (in_ch),
    .in_valid  (in_valid),
    .ok        (ok),
    .res_valid (res_valid),
    .res       (res),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one character for one edge, then sample 1 time unit after the edge.
  task automatic send(input logic [7:0] c);
    in_ch    = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (res_valid) begin
      res_log.push_back(res);
      err_log.push_back(err);
    end
  endtask

  task automatic idle(input int n, input logic [7:0] junk);
    in_valid = 1'b0;
    in_ch    = junk;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        res_log.push_back(res);
        err_log.push_back(err);
      end
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic clear_log;
    res_log.delete();
    err_log.delete();
  endtask

  task automatic test_reset;
    clr_n    = 1'b0;
    in_valid = 1'b0;
    in_ch    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ok !== 1'b0)        begin n_errors++; $display("FAIL reset_ok got %b want 0", ok); end
    n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_checks++; if (res !== 16'd0)      begin n_errors++; $display("FAIL reset_res got %0d want 0", res); end
    n_checks++; if (err !== 1'b0)       begin n_errors++; $display("FAIL reset_err got %b want 0", err); end
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_precedence;
    string      s;
    logic [5:0] exp_ok;
    s      = "1+2*3=";
    exp_ok = 6'b101010;
    clear_log();
    for (int i = 0; i < 6; i++) begin
      send(s[i]);
      n_checks++;
      if (ok !== exp_ok[5-i]) begin
        n_errors++;
        $display("FAIL prec_ok char %0d got %b want %b", i, ok, exp_ok[5-i]);
      end
    end
    n_checks++; if (res_log.size() != 1) begin n_errors++; $display("FAIL prec_pulses got %0d want 1", res_log.size()); end
    else begin
      n_checks++; if (res_log[0] !== 16'd7) begin n_errors++; $display("FAIL prec_res got %0d want 7", res_log[0]); end
      n_checks++; if (err_log[0] !== 1'b0)  begin n_errors++; $display("FAIL prec_err got %b want 0", err_log[0]); end
    end
    idle(2, 8'h35);
    n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL prec_pulse_width got %b want 0", res_valid); end
    n_checks++; if (res !== 16'd7)      begin n_errors++; $display("FAIL prec_res_hold got %0d want 7", res); end
    n_checks++; if (res_log.size() != 1) begin n_errors++; $display("FAIL prec_extra_pulse got %0d want 1", res_log.size()); end
  endtask

  task automatic test_wrap;
    clear_log();
    send_str("9*9*9*9*9=");
    send_str("9*9*9*9*9*9=");
    send_str("9*9*9*9*9+9*9*9*9*9=");
    send_str("2+3*4*5+6=");
    n_checks++; if (res_log.size() != 4) begin n_errors++; $display("FAIL wrap_pulses got %0d want 4", res_log.size()); end
    else begin
      n_checks++; if (res_log[0] !== 16'd59049) begin n_errors++; $display("FAIL wrap_9pow5 got %0d want 59049", res_log[0]); end
      n_checks++; if (res_log[1] !== 16'd7153)  begin n_errors++; $display("FAIL wrap_9pow6 got %0d want 7153", res_log[1]); end
      n_checks++; if (err_log[1] !== 1'b0)      begin n_errors++; $display("FAIL wrap_9pow6_err got %b want 0", err_log[1]); end
      n_checks++; if (res_log[2] !== 16'd52562) begin n_errors++; $display("FAIL wrap_add got %0d want 52562", res_log[2]); end
      n_checks++; if (res_log[3] !== 16'd68)    begin n_errors++; $display("FAIL mixed_prec got %0d want 68", res_log[3]); end
    end
  endtask

  task automatic test_errors;
    clear_log();
    send_str("1++");
    n_checks++; if (ok !== 1'b0) begin n_errors++; $display("FAIL err_dbl_op_ok got %b want 0", ok); end
    send("2");
    n_checks++; if (ok !== 1'b0) begin n_errors++; $display("FAIL err_sticky_ok got %b want 0", ok); end
    send("=");
    send_str("+3");
    n_checks++; if (ok !== 1'b0) begin n_errors++; $display("FAIL err_lead_op_ok got %b want 0", ok); end
    send("=");
    send_str("1a2=");
    send_str("5=");
    n_checks++; if (res_log.size() != 4) begin n_errors++; $display("FAIL err_pulses got %0d want 4", res_log.size()); end
    else begin
      n_checks++; if (err_log[0] !== 1'b1 || res_log[0] !== 16'd0) begin n_errors++; $display("FAIL err_dbl_op got err=%b res=%0d want err=1 res=0", err_log[0], res_log[0]); end
      n_checks++; if (err_log[1] !== 1'b1 || res_log[1] !== 16'd0) begin n_errors++; $display("FAIL err_lead_op got err=%b res=%0d want err=1 res=0", err_log[1], res_log[1]); end
      n_checks++; if (err_log[2] !== 1'b1 || res_log[2] !== 16'd0) begin n_errors++; $display("FAIL err_other got err=%b res=%0d want err=1 res=0", err_log[2], res_log[2]); end
      n_checks++; if (err_log[3] !== 1'b0 || res_log[3] !== 16'd5) begin n_errors++; $display("FAIL err_recover got err=%b res=%0d want err=0 res=5", err_log[3], res_log[3]); end
    end
  endtask

  task automatic test_back_to_back;
    clear_log();
    send_str("2*3+4=5+5==");
    n_checks++; if (res_log.size() != 3) begin n_errors++; $display("FAIL b2b_pulses got %0d want 3", res_log.size()); end
    else begin
      n_checks++; if (res_log[0] !== 16'd10 || err_log[0] !== 1'b0) begin n_errors++; $display("FAIL b2b_first got res=%0d err=%b want res=10 err=0", res_log[0], err_log[0]); end
      n_checks++; if (res_log[1] !== 16'd10 || err_log[1] !== 1'b0) begin n_errors++; $display("FAIL b2b_second got res=%0d err=%b want res=10 err=0", res_log[1], err_log[1]); end
      n_checks++; if (res_log[2] !== 16'd0 || err_log[2] !== 1'b1)  begin n_errors++; $display("FAIL b2b_empty got res=%0d err=%b want res=0 err=1", res_log[2], err_log[2]); end
    end
  endtask

  task automatic test_gaps;
    clear_log();
    send("4");
    idle(3, 8'h2B);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL gap_ok_hold got %b want 1", ok); end
    send("*");
    idle(2, 8'h39);
    n_checks++; if (ok !== 1'b0) begin n_errors++; $display("FAIL gap_ok_after_op got %b want 0", ok); end
    send("5");
    idle(2, 8'h3D);
    n_checks++; if (res_log.size() != 0) begin n_errors++; $display("FAIL gap_invalid_eq got %0d pulses want 0", res_log.size()); end
    send("=");
    n_checks++; if (res_log.size() != 1) begin n_errors++; $display("FAIL gap_pulses got %0d want 1", res_log.size()); end
    else begin
      n_checks++; if (res_log[0] !== 16'd20 || err_log[0] !== 1'b0) begin n_errors++; $display("FAIL gap_res got res=%0d err=%b want res=20 err=0", res_log[0], err_log[0]); end
    end
  endtask

  task automatic test_mid_reset;
    clear_log();
    send_str("7+8");
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL mrst_pre_ok got %b want 1", ok); end
    #2;
    clr_n = 1'b0;
    #1;
    n_checks++; if (ok !== 1'b0)   begin n_errors++; $display("FAIL mrst_ok got %b want 0", ok); end
    n_checks++; if (res !== 16'd0) begin n_errors++; $display("FAIL mrst_res got %0d want 0", res); end
    n_checks++; if (res_valid !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL mrst_flags got rv=%b err=%b want 0 0", res_valid, err); end
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    idle(2, 8'h3D);
    n_checks++; if (res_log.size() != 0) begin n_errors++; $display("FAIL mrst_no_pulse got %0d want 0", res_log.size()); end
    send_str("3=");
    n_checks++; if (res_log.size() != 1) begin n_errors++; $display("FAIL mrst_pulses got %0d want 1", res_log.size()); end
    else begin
      n_checks++; if (res_log[0] !== 16'd3 || err_log[0] !== 1'b0) begin n_errors++; $display("FAIL mrst_res_after got res=%0d err=%b want res=3 err=0", res_log[0], err_log[0]); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_precedence();
    test_wrap();
    test_errors();
    test_back_to_back();
    test_gaps();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
